// File: rtl/svi_pkg.sv
// Shared types and constants for the SVI SDRAM port arbiter.
package svi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam logic [1:0] GNT_DL  = 2'd0;
  localparam logic [1:0] GNT_CLR = 2'd1;
  localparam logic [1:0] GNT_CPU = 2'd2;
  localparam logic [1:0] GNT_CAS = 2'd3;

  localparam logic [7:0] RD_TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/svi_sdram_arb_if.sv
// Requester, SDRAM-controller and status signals of the arbiter.
// slave = arbiter view, master = surrounding logic (requesters + controller).
interface svi_sdram_arb_if #(
  parameter int ADDR_W = 23
);
  logic              dl_req;
  logic [ADDR_W-1:0] dl_addr;
  logic [7:0]        dl_data;
  logic              dl_ack;

  logic              clr_req;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_ack;

  logic              cpu_rd;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic [7:0]        cpu_dout;
  logic              cpu_ack;

  logic              cas_req;
  logic [ADDR_W-1:0] cas_addr;
  logic [7:0]        cas_dout;
  logic              cas_ack;
  logic              cas_rfsh_n;

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_rd;
  logic              mem_we;
  logic [7:0]        mem_dout;
  logic              mem_ready;

  logic [1:0]        grant;
  logic              busy;
  logic              timeout_err;

  modport slave (
    input  dl_req, dl_addr, dl_data, clr_req, clr_addr,
           cpu_rd, cpu_we, cpu_addr, cpu_din, cas_req, cas_addr, cas_rfsh_n,
           mem_dout, mem_ready,
    output dl_ack, clr_ack, cpu_dout, cpu_ack, cas_dout, cas_ack,
           mem_addr, mem_din, mem_rd, mem_we, grant, busy, timeout_err
  );

  modport master (
    output dl_req, dl_addr, dl_data, clr_req, clr_addr,
           cpu_rd, cpu_we, cpu_addr, cpu_din, cas_req, cas_addr, cas_rfsh_n,
           mem_dout, mem_ready,
    input  dl_ack, clr_ack, cpu_dout, cpu_ack, cas_dout, cas_ack,
           mem_addr, mem_din, mem_rd, mem_we, grant, busy, timeout_err
  );
endinterface

// File: rtl/svi_arb_prio.sv
// Fixed-priority pick dl > clr > cpu > cas; an aged, eligible cas jumps
// ahead of clr and cpu but never ahead of dl.
module svi_arb_prio
  import svi_pkg::*;
(
  input  logic [3:0] req,       // bit index = grant id
  input  logic       cas_ok,
  input  logic       cas_aged,
  output logic [1:0] gnt_id,
  output logic       gnt_vld
);

  logic [3:0] elig;

  assign elig = {req[GNT_CAS] & cas_ok, req[GNT_CPU], req[GNT_CLR], req[GNT_DL]};

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    gnt_id  = GNT_DL;
    gnt_vld = |elig;
    if (elig[GNT_DL])                    gnt_id = GNT_DL;
    else if (elig[GNT_CAS] && cas_aged)  gnt_id = GNT_CAS;
    else if (elig[GNT_CLR])              gnt_id = GNT_CLR;
    else if (elig[GNT_CPU])              gnt_id = GNT_CPU;
    else if (elig[GNT_CAS])              gnt_id = GNT_CAS;
  end

endmodule

// File: rtl/svi_sdram_arb.sv
// Single-transaction SDRAM port arbiter for dl / clr / cpu / cas requesters.
// Optional `SVI_CAS_WINDOW_EN: cas only eligible while cas_rfsh_n is low.
module svi_sdram_arb
  import svi_pkg::*;
#(
  parameter int ADDR_W       = 23,
  parameter int CAS_MAX_WAIT = 8,
  parameter int TIMEOUT      = 63
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  svi_sdram_arb_if.slave  bus
);

  arb_state_t        state, state_nxt;
  logic [1:0]        owner;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              we_q;
  logic [7:0]        wait_cnt;
  logic [7:0]        cas_wait_cnt;

  logic [1:0]        pick_id;
  logic              pick_vld;
  logic              cas_ok;
  logic [ADDR_W-1:0] pick_addr;
  logic [7:0]        pick_data;
  logic              pick_we;
  logic              ready_hit;
  logic              time_hit;

`ifdef SVI_CAS_WINDOW_EN
  assign cas_ok = ~bus.cas_rfsh_n;
`else
  logic unused_rfsh;
  assign cas_ok      = 1'b1;
  assign unused_rfsh = bus.cas_rfsh_n;
`endif

  svi_arb_prio u_prio (
    .req      ({bus.cas_req, bus.cpu_rd | bus.cpu_we, bus.clr_req, bus.dl_req}),
    .cas_ok   (cas_ok),
    .cas_aged (cas_wait_cnt >= 8'(CAS_MAX_WAIT)),
    .gnt_id   (pick_id),
    .gnt_vld  (pick_vld)
  );

  // The first WAIT cycle (wait_cnt == 0) ignores mem_ready: the controller
  // has not yet captured the strobe and still reports idle.
  assign ready_hit = (state == ST_WAIT) && (wait_cnt != 8'd0) && bus.mem_ready;
  assign time_hit  = (state == ST_WAIT) && !ready_hit && (wait_cnt == 8'(TIMEOUT));

  always_ff @(posedge clk_sys) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (pick_vld) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (ready_hit || time_hit) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pick_addr = bus.dl_addr;
    pick_data = bus.dl_data;
    pick_we   = 1'b1;
    unique case (pick_id)
      GNT_CLR: begin pick_addr = bus.clr_addr; pick_data = 8'h00;       pick_we = 1'b1;       end
      GNT_CPU: begin pick_addr = bus.cpu_addr; pick_data = bus.cpu_din; pick_we = bus.cpu_we; end
      GNT_CAS: begin pick_addr = bus.cas_addr; pick_data = 8'h00;       pick_we = 1'b0;       end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      owner        <= GNT_DL;
      addr_q       <= '0;
      data_q       <= 8'h00;
      we_q         <= 1'b0;
      wait_cnt     <= 8'd0;
      cas_wait_cnt <= 8'd0;
      bus.cpu_dout <= 8'h00;
      bus.cas_dout <= 8'h00;
      bus.timeout_err <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (pick_vld) begin
          owner  <= pick_id;
          addr_q <= pick_addr;
          data_q <= pick_data;
          we_q   <= pick_we;
        end
        ST_ISSUE: wait_cnt <= 8'd0;
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (time_hit) bus.timeout_err <= 1'b1;
          // Read data is registered here so it is already stable during the ack.
          if ((ready_hit || time_hit) && !we_q) begin
            if (owner == GNT_CPU) bus.cpu_dout <= ready_hit ? bus.mem_dout : RD_TIMEOUT_DATA;
            if (owner == GNT_CAS) bus.cas_dout <= ready_hit ? bus.mem_dout : RD_TIMEOUT_DATA;
          end
        end
        ST_DONE: begin
          if (owner == GNT_CAS)
            cas_wait_cnt <= 8'd0;
          else if (bus.cas_req && cas_wait_cnt != 8'hFF)
            cas_wait_cnt <= cas_wait_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.mem_rd  = (state == ST_ISSUE) && !we_q;
    bus.mem_we  = (state == ST_ISSUE) && we_q;
    bus.dl_ack  = (state == ST_DONE) && (owner == GNT_DL);
    bus.clr_ack = (state == ST_DONE) && (owner == GNT_CLR);
    bus.cpu_ack = (state == ST_DONE) && (owner == GNT_CPU);
    bus.cas_ack = (state == ST_DONE) && (owner == GNT_CAS);
    bus.busy    = (state != ST_IDLE);
  end

  assign bus.grant    = owner;
  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = data_q;

endmodule

// File: tb/tb_svi_sdram_arb.sv
// Scoreboard bench for svi_sdram_arb: stimulus queues expected commands/acks,
// a monitor checks strobes and acks as the DUT presents them.
module tb_svi_sdram_arb;
  import svi_pkg::*;

  localparam int ADDR_W = 23;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    bit         chk_data;
    bit         to;
    int         req_cyc;  // -1: no request-to-ack latency check
    int         lat;      // ack cycles after strobe, -1: skip
  } ack_exp_t;

  typedef struct {
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        din;
  } cmd_exp_t;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   ready_delay = 2;  // <0: controller never reports ready
  bit   hold_cpu = 1'b0;

  ack_exp_t ack_q[$];
  cmd_exp_t cmd_q[$];

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  svi_sdram_arb_if #(.ADDR_W(ADDR_W)) bus ();

  svi_sdram_arb #(.ADDR_W(ADDR_W), .CAS_MAX_WAIT(3), .TIMEOUT(10)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SDRAM controller model: ready drops on a strobe, rises ready_delay cycles later.
  initial begin
    int d;
    logic [7:0] v;
    bus.mem_ready = 1'b1;
    bus.mem_dout  = 8'h00;
    forever begin
      @(negedge clk_sys);
      if (bus.mem_rd || bus.mem_we) begin
        d = ready_delay;
        v = bus.mem_addr[7:0] ^ 8'h3C;
        bus.mem_ready = 1'b0;
        bus.mem_dout  = 8'hEE;
        if (d > 0) begin
          repeat (d) @(negedge clk_sys);
          bus.mem_ready = 1'b1;
          bus.mem_dout  = v;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    bit       pend;
    logic [1:0] pid;
    logic [7:0] pdata;
    int       strobe_cyc;
    int       n_ack;
    logic [1:0] act_id;
    cmd_exp_t c;
    ack_exp_t e;
    pend = 1'b0;
    strobe_cyc = 0;
    forever begin
      @(negedge clk_sys);
      if (pend) begin
        if (pid == GNT_CPU) check("cpu_dout", bus.cpu_dout, pdata);
        else                check("cas_dout", bus.cas_dout, pdata);
        pend = 1'b0;
      end
      if (bus.mem_rd || bus.mem_we) begin
        strobe_cyc = cyc;
        check("cmd_expected", cmd_q.size() != 0, 1);
        if (cmd_q.size() != 0) begin
          c = cmd_q.pop_front();
          check("cmd_dir", {bus.mem_rd, bus.mem_we}, c.we ? 2'b01 : 2'b10);
          check("cmd_addr", bus.mem_addr, c.addr);
          if (c.we) check("cmd_din", bus.mem_din, c.din);
        end
      end
      n_ack = int'(bus.dl_ack) + int'(bus.clr_ack) + int'(bus.cpu_ack) + int'(bus.cas_ack);
      if (n_ack != 0) begin
        check("ack_onehot", n_ack, 1);
        check("ack_expected", ack_q.size() != 0, 1);
        act_id = bus.clr_ack ? GNT_CLR : bus.cpu_ack ? GNT_CPU : bus.cas_ack ? GNT_CAS : GNT_DL;
        if (ack_q.size() != 0) begin
          e = ack_q.pop_front();
          check("ack_owner", act_id, e.id);
          check("ack_grant", bus.grant, e.id);
          check("ack_busy", bus.busy, 1);
          check("ack_timeout_err", bus.timeout_err, e.to);
          if (e.lat >= 0) check("strobe_to_ack", cyc - strobe_cyc, e.lat);
          if (e.req_cyc >= 0) check("req_to_ack", cyc - e.req_cyc, 4);
          if (e.chk_data) begin
            pend  = 1'b1;
            pid   = e.id;
            pdata = e.data;
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk_sys);
    if (bus.dl_ack)  bus.dl_req  = 1'b0;
    if (bus.clr_ack) bus.clr_req = 1'b0;
    if (bus.cas_ack) bus.cas_req = 1'b0;
    if (bus.cpu_ack && !hold_cpu) begin
      bus.cpu_rd = 1'b0;
      bus.cpu_we = 1'b0;
    end
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((ack_q.size() != 0 || bus.busy) && n < budget) begin
      step();
      n++;
    end
    check({name, "_acks_outstanding"}, ack_q.size(), 0);
  endtask

  task automatic check_reset(input string name);
    check({name, "_busy"}, bus.busy, 0);
    check({name, "_grant"}, bus.grant, GNT_DL);
    check({name, "_acks"}, {bus.dl_ack, bus.clr_ack, bus.cpu_ack, bus.cas_ack}, 4'h0);
    check({name, "_strobes"}, {bus.mem_rd, bus.mem_we}, 2'b00);
    check({name, "_cpu_dout"}, bus.cpu_dout, 8'h00);
    check({name, "_cas_dout"}, bus.cas_dout, 8'h00);
    check({name, "_timeout_err"}, bus.timeout_err, 0);
  endtask

  function automatic ack_exp_t mk_ack(logic [1:0] id, logic [7:0] data, bit chk, bit to,
                                      int req_cyc, int lat);
    ack_exp_t a;
    a.id = id; a.data = data; a.chk_data = chk; a.to = to; a.req_cyc = req_cyc; a.lat = lat;
    return a;
  endfunction

  function automatic cmd_exp_t mk_cmd(bit we, logic [ADDR_W-1:0] addr, logic [7:0] din);
    cmd_exp_t m;
    m.we = we; m.addr = addr; m.din = din;
    return m;
  endfunction

  initial begin
    bus.dl_req = 0; bus.dl_addr = '0; bus.dl_data = 0;
    bus.clr_req = 0; bus.clr_addr = '0;
    bus.cpu_rd = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_din = 0;
    bus.cas_req = 0; bus.cas_addr = '0; bus.cas_rfsh_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    check_reset("reset");
    reset_n = 1'b1;
    step();

    // Single CPU write, ready 2 cycles after the strobe: ack 4 cycles after request
    bus.cpu_we = 1; bus.cpu_addr = 23'h00100; bus.cpu_din = 8'h5A;
    cmd_q.push_back(mk_cmd(1, 23'h00100, 8'h5A));
    ack_q.push_back(mk_ack(GNT_CPU, 8'h00, 0, 0, cyc, 3));
    drain(20, "cpu_write");

    // dl, clr, cpu together; cpu has rd and we both high -> write
    bus.dl_req = 1;  bus.dl_addr = 23'h7FFFFF; bus.dl_data = 8'hA1;
    bus.clr_req = 1; bus.clr_addr = 23'h000001;
    bus.cpu_rd = 1;  bus.cpu_we = 1; bus.cpu_addr = 23'h12345; bus.cpu_din = 8'hC3;
    cmd_q.push_back(mk_cmd(1, 23'h7FFFFF, 8'hA1));
    cmd_q.push_back(mk_cmd(1, 23'h000001, 8'h00));
    cmd_q.push_back(mk_cmd(1, 23'h12345, 8'hC3));
    ack_q.push_back(mk_ack(GNT_DL,  8'h00, 0, 0, -1, 3));
    ack_q.push_back(mk_ack(GNT_CLR, 8'h00, 0, 0, -1, 3));
    ack_q.push_back(mk_ack(GNT_CPU, 8'h00, 0, 0, -1, 3));
    drain(60, "priority");

    // Aging: cpu back-to-back, cas held -> cas right after the 3rd cpu DONE
    hold_cpu = 1'b1;
    bus.cas_rfsh_n = 1'b0;
    bus.cpu_rd = 1; bus.cpu_addr = 23'h00300;
    bus.cas_req = 1; bus.cas_addr = 23'h40010;
    for (int i = 0; i < 3; i++) begin
      cmd_q.push_back(mk_cmd(0, 23'h00300, 8'h00));
      ack_q.push_back(mk_ack(GNT_CPU, 8'h3C, 1, 0, -1, 3));
    end
    cmd_q.push_back(mk_cmd(0, 23'h40010, 8'h00));
    ack_q.push_back(mk_ack(GNT_CAS, 8'h2C, 1, 0, -1, 3));
    for (int n = 0; n < 80; n++) begin
      step();
      if (bus.cas_ack) break;
    end
    hold_cpu = 1'b0;
    bus.cpu_rd = 0;
    bus.cas_rfsh_n = 1'b1;
    drain(20, "aging");

    // Timeout: mem_ready never returns on a CPU read
    ready_delay = -1;
    bus.cpu_rd = 1; bus.cpu_addr = 23'h00200;
    cmd_q.push_back(mk_cmd(0, 23'h00200, 8'h00));
    ack_q.push_back(mk_ack(GNT_CPU, RD_TIMEOUT_DATA, 1, 1, -1, 12));
    drain(40, "timeout");
    step();

    // Reset pulsed during WAIT: transaction abandoned, no ack
    bus.cpu_rd = 1; bus.cpu_addr = 23'h00210;
    cmd_q.push_back(mk_cmd(0, 23'h00210, 8'h00));
    repeat (4) step();
    check("busy_in_wait", bus.busy, 1);
    reset_n = 1'b0;
    bus.cpu_rd = 0;
    step();
    check_reset("mid_reset");
    reset_n = 1'b1;
    ready_delay = 2;
    step();

    // cas window: with the window feature cas waits for cas_rfsh_n low
    bus.cas_req = 1; bus.cas_addr = 23'h40055;
`ifdef SVI_CAS_WINDOW_EN
    repeat (8) step();
    check("cas_blocked_busy", bus.busy, 0);
    bus.cas_rfsh_n = 1'b0;
`endif
    cmd_q.push_back(mk_cmd(0, 23'h40055, 8'h00));
    ack_q.push_back(mk_ack(GNT_CAS, 8'h69, 1, 0, cyc, 3));
    drain(20, "cas_window");
    bus.cas_rfsh_n = 1'b1;

    repeat (3) step();
    check("cmds_outstanding", cmd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
